evt_readout_arb: RTL and testbench
==================================

# evt_readout_arb

Two-source event readout arbiter for the alpha/gamma counter cores. It takes head-of-FIFO event records from two counter instances and grants them round-robin or by fixed priority, acknowledging each consumed record to its source. Granted records are packed into 64-bit words and presented on a valid/ready stream toward the DMA/bus readout path. This replaces per-event software polling of the three readout registers.

## Interface
Parameters:
- `TS_W`, 32: t0 width; must be 32 for the packing below.

Ports:
- `clk_i` in 1: system clock; all logic is in this single domain.
- `rst_i` in 1: reset, asynchronous, active-high.
- `enable_i` in 1: when high, new grants are allowed.
- `mode_i` in 1: grant policy; 0 = round-robin, 1 = fixed priority to source 0.
- `clr_i` in 1: one-cycle pulse that clears the statistics counters.
- `srcN_vld_i` in 1, N=0,1: source N's head record is valid.
- `srcN_type_i` in 1: event type; 0 = alpha, 1 = gamma.
- `srcN_amp_i` in 14: signed peak amplitude.
- `srcN_t0_i` in 32: inter-event timestamp.
- `srcN_t1_i` in 16: pulse width.
- `srcN_ack_o` out 1: one-cycle pulse meaning the record was consumed.
- `m_vld_o` out 1: output word is valid.
- `m_data_o` out 64: packed record.
- `m_rdy_i` in 1: downstream ready.
- `cnt_w0_o`, `cnt_w1_o` out 32: words delivered per source.
- `stall_o` out 32: stall cycles, counted when `m_vld_o & !m_rdy_i`.

## Operation
- FSM states: IDLE and XFER.
- **IDLE:** if `enable_i` is high and either `srcN_vld_i` is high, select the winner.
  - Capture the winner's record into the output register.
  - Pulse the winner's `srcN_ack_o` for exactly the first XFER cycle.
  - Update the last-grant pointer and go to XFER.
- **Winner selection:**
  - Only one source valid: that source wins.
  - Both valid, `mode_i`=1: source 0 wins.
  - Both valid, `mode_i`=0: the source not granted last wins.
- **XFER:** hold `m_vld_o`=1 with `m_data_o` stable. When `m_vld_o & m_rdy_i`, go to IDLE.
- **Packing of `m_data_o`:**
  - [63] = source id.
  - [62] = type.
  - [61:48] = amp, raw 14-bit two's complement.
  - [47:32] = t1.
  - [31:0] = t0.
- `srcN_*` inputs are sampled only in IDLE. A source must update or drop `vld` on the edge that ends its ack cycle.
- `enable_i` falling during XFER: the current word still completes; no new grant follows.
- `m_rdy_i` is ignored in IDLE.

## Timing
- **Reset values:**
  - State IDLE; `m_vld_o`=0; `m_data_o`=0; both `srcN_ack_o`=0.
  - Last-grant pointer = 1, so source 0 wins the first contention.
  - All counters = 0.
- **Latency:** `srcN_vld_i` sampled high at edge E0 → `m_vld_o` and `srcN_ack_o` high in the cycle after E0.
- **Throughput:** at most one word every 2 cycles (IDLE + XFER), even with `m_rdy_i` held high.
- **Ack:** exactly one pulse per granted record, never repeated while a word is stalled.
- **Reset during XFER:** `m_vld_o` drops asynchronously and the word is lost. The source was already acked, so the record is not re-sent.
- **Simultaneous valid:** both sources high every IDLE with `mode_i`=0 → grants strictly alternate 0,1,0,1.
- **`mode_i` changes:** take effect at the next IDLE decision.

## Configuration
- Macro `EVT_ARB_STATS_EN`.
- **Defined:**
  - `cnt_w0_o`/`cnt_w1_o` increment on each output handshake of the matching source id.
  - `stall_o` increments per stall cycle.
  - All three saturate at 0xFFFFFFFF and do not wrap.
  - `clr_i` zeroes them and wins over a same-cycle increment.
- **Undefined:** the counter logic is not built; all three outputs are constant 0 and `clr_i` is ignored.

## Test plan
- **Single record:** reset, `enable_i`=1, `src0_vld_i`=1 with type=1, amp=-100, t0=0x12345678, t1=0x00AB, `m_rdy_i`=1.
  - `m_data_o`=0x7F9C00AB12345678 one cycle after sampling, with a single `src0_ack_o` pulse.
  - Source then drops `vld`; no further output.
- **Round-robin contention:** both sources valid continuously, `mode_i`=0, `m_rdy_i`=1.
  - Ids 0,1,0,1 on 4 words over 8 cycles, 2 acks each.
- **Fixed priority:** same stimulus with `mode_i`=1.
  - Four words all from id 0; `src1_ack_o` never pulses.
- **Backpressure:** `m_rdy_i`=0 for 10 cycles after a grant.
  - `m_data_o` stable and ack pulsed once.
  - `stall_o`=10 with the macro defined, 0 without.
  - Word delivered on the first cycle `m_rdy_i`=1.
- **Reset mid-XFER:** assert `rst_i` during XFER.
  - `m_vld_o`=0 immediately; counters 0; pointer restored so source 0 wins the next contention.
- **Counter saturation and clear:** force `cnt_w0_o` to 0xFFFFFFFE, deliver 3 source-0 words.
  - Reads 0xFFFFFFFF.
  - `clr_i` pulsed together with a handshake → 0.

Source files
------------

// File: rtl/evt_readout_arb.sv
// evt_readout_arb
//   Two-source event readout arbiter. The head records of two counter cores
//   are granted round-robin (mode_i=0) or with fixed priority to source 0
//   (mode_i=1). Each granted record is packed into a 64-bit word and held on
//   a valid/ready stream. The winning source receives a one-cycle ack in the
//   first cycle of the transfer.
//
//   Packed word: [63] source id, [62] type, [61:48] amp, [47:32] t1, [31:0] t0
//
//   Optional feature: define EVT_ARB_STATS_EN to build the saturating
//   per-source word counters and the stall counter. Without it, cnt_w0_o,
//   cnt_w1_o and stall_o are tied to 0 and clr_i is ignored.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   enable_i, mode_i      grant enable, grant policy
//   clr_i                 statistics clear pulse
//   srcN_vld/type/amp/t0/t1_i, srcN_ack_o   source N head record and ack
//   m_vld_o, m_data_o, m_rdy_i              output stream
//   cnt_w0_o, cnt_w1_o, stall_o             statistics
module evt_readout_arb #(
  parameter int unsigned TS_W = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic            mode_i,
  input  logic            clr_i,
  input  logic            src0_vld_i,
  input  logic            src0_type_i,
  input  logic [13:0]     src0_amp_i,
  input  logic [TS_W-1:0] src0_t0_i,
  input  logic [15:0]     src0_t1_i,
  output logic            src0_ack_o,
  input  logic            src1_vld_i,
  input  logic            src1_type_i,
  input  logic [13:0]     src1_amp_i,
  input  logic [TS_W-1:0] src1_t0_i,
  input  logic [15:0]     src1_t1_i,
  output logic            src1_ack_o,
  output logic            m_vld_o,
  output logic [63:0]     m_data_o,
  input  logic            m_rdy_i,
  output logic [31:0]     cnt_w0_o,
  output logic [31:0]     cnt_w1_o,
  output logic [31:0]     stall_o
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;   // id of the most recent grant
  logic [63:0] data_q, data_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        win;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    data_d  = data_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    win     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i && (src0_vld_i || src1_vld_i)) begin
          if (src0_vld_i && src1_vld_i)
            win = mode_i ? 1'b0 : ~last_q;
          else
            win = src1_vld_i;
          data_d  = win ? {1'b1, src1_type_i, src1_amp_i, src1_t1_i, src1_t0_i}
                        : {1'b0, src0_type_i, src0_amp_i, src0_t1_i, src0_t0_i};
          ack0_d  = ~win;
          ack1_d  = win;
          last_d  = win;
          state_d = XFER;
        end
      end
      XFER: begin
        if (m_rdy_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      data_q  <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      data_q  <= data_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  // Valid is decoded straight from the state so reset drops it asynchronously.
  assign m_vld_o    = (state_q == XFER);
  assign m_data_o   = data_q;
  assign src0_ack_o = ack0_q;
  assign src1_ack_o = ack1_q;

`ifdef EVT_ARB_STATS_EN
  logic [31:0] cnt_w0_q, cnt_w1_q, stall_q;
  logic        hs;

  assign hs = m_vld_o & m_rdy_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_w0_q <= '0;
      cnt_w1_q <= '0;
      stall_q  <= '0;
    end else if (clr_i) begin
      cnt_w0_q <= '0;
      cnt_w1_q <= '0;
      stall_q  <= '0;
    end else begin
      if (hs && !data_q[63] && (cnt_w0_q != '1))
        cnt_w0_q <= cnt_w0_q + 32'd1;
      if (hs && data_q[63] && (cnt_w1_q != '1))
        cnt_w1_q <= cnt_w1_q + 32'd1;
      if (m_vld_o && !m_rdy_i && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
    end
  end

  assign cnt_w0_o = cnt_w0_q;
  assign cnt_w1_o = cnt_w1_q;
  assign stall_o  = stall_q;
`else
  logic unused_clr;
  assign unused_clr = clr_i;
  assign cnt_w0_o   = '0;
  assign cnt_w1_o   = '0;
  assign stall_o    = '0;
`endif

endmodule

// File: tb/tb_evt_readout_arb.sv
module tb_evt_readout_arb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i, mode_i, clr_i;
  logic        src0_vld_i, src0_type_i, src1_vld_i, src1_type_i;
  logic [13:0] src0_amp_i, src1_amp_i;
  logic [31:0] src0_t0_i, src1_t0_i;
  logic [15:0] src0_t1_i, src1_t1_i;
  logic        src0_ack_o, src1_ack_o;
  logic        m_vld_o, m_rdy_i;
  logic [63:0] m_data_o;
  logic [31:0] cnt_w0_o, cnt_w1_o, stall_o;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  evt_readout_arb #(.TS_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .mode_i(mode_i), .clr_i(clr_i),
    .src0_vld_i(src0_vld_i), .src0_type_i(src0_type_i), .src0_amp_i(src0_amp_i),
    .src0_t0_i(src0_t0_i), .src0_t1_i(src0_t1_i), .src0_ack_o(src0_ack_o),
    .src1_vld_i(src1_vld_i), .src1_type_i(src1_type_i), .src1_amp_i(src1_amp_i),
    .src1_t0_i(src1_t0_i), .src1_t1_i(src1_t1_i), .src1_ack_o(src1_ack_o),
    .m_vld_o(m_vld_o), .m_data_o(m_data_o), .m_rdy_i(m_rdy_i),
    .cnt_w0_o(cnt_w0_o), .cnt_w1_o(cnt_w1_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic en, mode, v0, v1, rdy;
    logic e_vld, e_a0, e_a1, e_id;
  } vec_t;

  vec_t tab[26];

  // Fixed records presented by each source during the table phase
  localparam logic [63:0] EXP0 = {1'b0, 1'b0, 14'h0123, 16'h1111, 32'hAAAA_0000};
  localparam logic [63:0] EXP1 = {1'b1, 1'b1, 14'h2FED, 16'h2222, 32'hBBBB_0001};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic vec_t mk(input logic en, mode, v0, v1, rdy, e_vld, e_a0, e_a1, e_id);
    vec_t v;
    v.en = en; v.mode = mode; v.v0 = v0; v.v1 = v1; v.rdy = rdy;
    v.e_vld = e_vld; v.e_a0 = e_a0; v.e_a1 = e_a1; v.e_id = e_id;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    enable_i = 1'b0; mode_i = 1'b0; clr_i = 1'b0; m_rdy_i = 1'b0;
    src0_vld_i = 1'b0; src1_vld_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic load_table_records();
    src0_type_i = 1'b0; src0_amp_i = 14'h0123; src0_t1_i = 16'h1111; src0_t0_i = 32'hAAAA_0000;
    src1_type_i = 1'b1; src1_amp_i = 14'h2FED; src1_t1_i = 16'h2222; src1_t0_i = 32'hBBBB_0001;
  endtask

  initial begin
    // en mode v0 v1 rdy | vld a0 a1 id
    // round-robin, both valid: 0,1,0,1
    tab[0]  = mk(1,0,1,1,1, 1,1,0,0);  tab[1]  = mk(1,0,1,1,1, 0,0,0,0);
    tab[2]  = mk(1,0,1,1,1, 1,0,1,1);  tab[3]  = mk(1,0,1,1,1, 0,0,0,0);
    tab[4]  = mk(1,0,1,1,1, 1,1,0,0);  tab[5]  = mk(1,0,1,1,1, 0,0,0,0);
    tab[6]  = mk(1,0,1,1,1, 1,0,1,1);  tab[7]  = mk(1,0,1,1,1, 0,0,0,0);
    // fixed priority: always source 0
    tab[8]  = mk(1,1,1,1,1, 1,1,0,0);  tab[9]  = mk(1,1,1,1,1, 0,0,0,0);
    tab[10] = mk(1,1,1,1,1, 1,1,0,0);  tab[11] = mk(1,1,1,1,1, 0,0,0,0);
    tab[12] = mk(1,1,1,1,1, 1,1,0,0);  tab[13] = mk(1,1,1,1,1, 0,0,0,0);
    tab[14] = mk(1,1,1,1,1, 1,1,0,0);  tab[15] = mk(1,1,1,1,1, 0,0,0,0);
    // back to round-robin: last grant was 0, so source 1 wins
    tab[16] = mk(1,0,1,1,1, 1,0,1,1);  tab[17] = mk(1,0,1,1,1, 0,0,0,0);
    // only source 1 valid in priority mode still wins
    tab[18] = mk(1,1,0,1,1, 1,0,1,1);  tab[19] = mk(1,1,0,1,1, 0,0,0,0);
    // enable low: no grant
    tab[20] = mk(0,0,1,1,1, 0,0,0,0);  tab[21] = mk(0,0,1,1,1, 0,0,0,0);
    // grant with rdy low in IDLE, enable falls during XFER, word completes, no regrant
    tab[22] = mk(1,0,1,1,0, 1,1,0,0);  tab[23] = mk(0,0,1,1,0, 1,0,0,0);
    tab[24] = mk(0,0,1,1,1, 0,0,0,0);  tab[25] = mk(0,0,1,1,1, 0,0,0,0);
  end

  initial begin
    logic [63:0] exp_w;

    rst_i = 1'b1;
    enable_i = 1'b0; mode_i = 1'b0; clr_i = 1'b0; m_rdy_i = 1'b0;
    src0_vld_i = 1'b0; src1_vld_i = 1'b0;
    src0_type_i = 1'b0; src1_type_i = 1'b0;
    src0_amp_i = '0; src1_amp_i = '0; src0_t0_i = '0; src1_t0_i = '0;
    src0_t1_i = '0; src1_t1_i = '0;
    #1;
    chk("rst_vld",  {63'd0, m_vld_o}, 64'd0);
    chk("rst_data", m_data_o, 64'd0);
    chk("rst_ack",  {62'd0, src0_ack_o, src1_ack_o}, 64'd0);
    chk("rst_cnt",  {cnt_w0_o, cnt_w1_o | stall_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // ---- single record ----
    @(negedge clk_i);
    enable_i = 1'b1; m_rdy_i = 1'b1;
    src0_vld_i = 1'b1; src0_type_i = 1'b1; src0_amp_i = 14'h3F9C;
    src0_t0_i = 32'h1234_5678; src0_t1_i = 16'h00AB;
    tick();
    chk("single_vld",  {63'd0, m_vld_o}, 64'd1);
    chk("single_data", m_data_o, 64'h7F9C_00AB_1234_5678);
    chk("single_ack",  {62'd0, src0_ack_o, src1_ack_o}, 64'd2);
    @(negedge clk_i);
    src0_vld_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("single_idle", {61'd0, m_vld_o, src0_ack_o, src1_ack_o}, 64'd0);
    end

    // ---- table-driven vectors ----
    do_reset();
    load_table_records();
    for (int i = 0; i < 26; i++) begin
      @(negedge clk_i);
      enable_i = tab[i].en; mode_i = tab[i].mode;
      src0_vld_i = tab[i].v0; src1_vld_i = tab[i].v1; m_rdy_i = tab[i].rdy;
      tick();
      chk($sformatf("tab%0d_vld", i), {63'd0, m_vld_o}, {63'd0, tab[i].e_vld});
      chk($sformatf("tab%0d_ack", i), {62'd0, src0_ack_o, src1_ack_o},
          {62'd0, tab[i].e_a0, tab[i].e_a1});
      if (tab[i].e_vld)
        chk($sformatf("tab%0d_data", i), m_data_o, tab[i].e_id ? EXP1 : EXP0);
    end
`ifndef EVT_ARB_STATS_EN
    chk("nostats_cnt", {cnt_w0_o, cnt_w1_o}, 64'd0);
`endif

    // ---- backpressure ----
    do_reset();
    load_table_records();
    @(negedge clk_i);
    enable_i = 1'b1; mode_i = 1'b0; src0_vld_i = 1'b1; m_rdy_i = 1'b0;
    tick();
    chk("bp_grant", {61'd0, m_vld_o, src0_ack_o, src1_ack_o}, 64'd6);
    exp_w = EXP0;
    @(negedge clk_i);
    src0_vld_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp_hold%0d", i), {61'd0, m_vld_o, src0_ack_o, src1_ack_o}, 64'd4);
      chk($sformatf("bp_data%0d", i), m_data_o, exp_w);
    end
`ifdef EVT_ARB_STATS_EN
    chk("bp_stall", {32'd0, stall_o}, 64'd10);
`else
    chk("bp_stall", {32'd0, stall_o}, 64'd0);
`endif
    @(negedge clk_i);
    m_rdy_i = 1'b1;
    tick();
    chk("bp_done", {63'd0, m_vld_o}, 64'd0);
`ifdef EVT_ARB_STATS_EN
    chk("bp_cnt0", {32'd0, cnt_w0_o}, 64'd1);
`else
    chk("bp_cnt0", {32'd0, cnt_w0_o}, 64'd0);
`endif

    // ---- reset mid-XFER: grant source 1, reset, then contention goes to 0 ----
    @(negedge clk_i);
    m_rdy_i = 1'b0; src1_vld_i = 1'b1;
    tick();
    chk("rx_grant1", {61'd0, m_vld_o, src0_ack_o, src1_ack_o}, 64'd5);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rx_vld_async", {63'd0, m_vld_o}, 64'd0);
    chk("rx_cnt", {cnt_w0_o, cnt_w1_o | stall_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    src0_vld_i = 1'b1; src1_vld_i = 1'b1; m_rdy_i = 1'b1;
    tick();
    chk("rx_contend", {61'd0, m_vld_o, src0_ack_o, src1_ack_o}, 64'd6);
    chk("rx_data", m_data_o, EXP0);

`ifdef EVT_ARB_STATS_EN
    // ---- saturation and clear ----
    do_reset();
    load_table_records();
    @(negedge clk_i);
    force dut.cnt_w0_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_w0_q;
    enable_i = 1'b1; mode_i = 1'b1; src0_vld_i = 1'b1; m_rdy_i = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("sat_cnt0", {32'd0, cnt_w0_o}, 64'hFFFF_FFFF);
    tick();
    chk("sat_vld", {63'd0, m_vld_o}, 64'd1);
    @(negedge clk_i);
    clr_i = 1'b1; src0_vld_i = 1'b0;
    tick();
    @(negedge clk_i);
    clr_i = 1'b0;
    chk("clr_cnt0", {32'd0, cnt_w0_o}, 64'd0);
    chk("clr_vld", {63'd0, m_vld_o}, 64'd0);
`else
    // ---- clr ignored when statistics are not built ----
    @(negedge clk_i);
    clr_i = 1'b1;
    tick();
    @(negedge clk_i);
    clr_i = 1'b0;
    chk("clr_ignored", {cnt_w0_o, stall_o}, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
